// File: rtl/mem_port_arbiter_if.sv
// Requester-side bundle of the memory port arbiter: per-port request,
// write/lock qualifiers, address/data slices and the shared grant/ack/rdata.
interface mem_port_arbiter_if #(
  parameter int unsigned NREQ = 2
);
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    we;
  logic [NREQ-1:0]    lock;
  logic [NREQ*17-1:0] addr;
  logic [NREQ*32-1:0] wdata;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    ack;
  logic [31:0]        rdata;

  modport master (
    output req, we, lock, addr, wdata,
    input  gnt, ack, rdata
  );

  modport slave (
    input  req, we, lock, addr, wdata,
    output gnt, ack, rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one core-memory bank between NREQ requesters,
// with a bank lock for read-modify-write sequences.
module mem_port_arbiter #(
  parameter int unsigned NREQ          = 2,
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  mem_port_arbiter_if.slave    bus,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [16:0]          mem_addr,
  output logic [31:0]          mem_wdata,
  input  logic [31:0]          mem_rdata
);

  localparam int unsigned IW = (NREQ > 2) ? 2 : 1;
  localparam logic [3:0] CNT_INIT = 4'(ACCESS_CYCLES - 1);

  typedef logic [IW-1:0] idx_t;
  typedef enum logic {IDLE, ACCESS} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  idx_t            last_q, last_d;
  idx_t            cur_q, cur_d;
  idx_t            owner_q, owner_d;
  logic            owner_vld_q, owner_vld_d;
  logic            lock_q, lock_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            mem_en_q, mem_en_d;
  logic            mem_we_q, mem_we_d;
  logic [16:0]     mem_addr_q, mem_addr_d;
  logic [31:0]     mem_wdata_q, mem_wdata_d;

  logic            rr_found;
  idx_t            rr_win;
  int unsigned     rr_idx;
  logic            owner_req;
  logic            pick_vld;
  idx_t            pick;
  logic            sel_we;
  logic            sel_lock;
  logic [16:0]     sel_addr;
  logic [31:0]     sel_wdata;

  function automatic logic [NREQ-1:0] onehot(input idx_t i);
    logic [NREQ-1:0] v;
    for (int unsigned k = 0; k < NREQ; k++) v[k] = (idx_t'(k) == i);
    return v;
  endfunction

  // Search from last+1 around the ring; first requester found wins.
  always_comb begin
    rr_found = 1'b0;
    rr_win   = '0;
    rr_idx   = 0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      rr_idx = 32'(last_q) + i;
      if (rr_idx >= NREQ) rr_idx = rr_idx - NREQ;
      for (int unsigned k = 0; k < NREQ; k++) begin
        if (!rr_found && k == rr_idx && bus.req[k]) begin
          rr_found = 1'b1;
          rr_win   = idx_t'(k);
        end
      end
    end
  end

  always_comb begin
    owner_req = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++)
      if (idx_t'(k) == owner_q) owner_req = bus.req[k];
    pick_vld = owner_vld_q ? owner_req : rr_found;
    pick     = owner_vld_q ? owner_q   : rr_win;
  end

  always_comb begin
    sel_we    = 1'b0;
    sel_lock  = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (idx_t'(k) == pick) begin
        sel_we    = bus.we[k];
        sel_lock  = bus.lock[k];
        sel_addr  = bus.addr[k*17 +: 17];
        sel_wdata = bus.wdata[k*32 +: 32];
      end
    end
  end

  // The lock qualifier is latched with the rest of the request in IDLE, so it
  // is the value presented at arbitration that decides ownership at completion.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    cur_d       = cur_q;
    owner_d     = owner_q;
    owner_vld_d = owner_vld_q;
    lock_d      = lock_q;
    gnt_d       = gnt_q;
    ack_d       = '0;
    rdata_d     = rdata_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      IDLE: begin
        if (owner_vld_q && !owner_req) begin
          owner_vld_d = 1'b0;
          gnt_d       = '0;
        end
        if (pick_vld) begin
          gnt_d       = onehot(pick);
          mem_en_d    = 1'b1;
          mem_we_d    = sel_we;
          mem_addr_d  = sel_addr;
          mem_wdata_d = sel_wdata;
          lock_d      = sel_lock;
          cur_d       = pick;
          last_d      = pick;
          cnt_d       = CNT_INIT;
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (!mem_we_q) rdata_d = mem_rdata;
          ack_d       = onehot(cur_q);
          mem_en_d    = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
          if (lock_q) begin
            owner_vld_d = 1'b1;
            owner_d     = cur_q;
          end else begin
            owner_vld_d = 1'b0;
            gnt_d       = '0;
          end
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_q      <= idx_t'(NREQ - 1);
      cur_q       <= '0;
      owner_q     <= '0;
      owner_vld_q <= 1'b0;
      lock_q      <= 1'b0;
      gnt_q       <= '0;
      ack_q       <= '0;
      rdata_q     <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      cur_q       <= cur_d;
      owner_q     <= owner_d;
      owner_vld_q <= owner_vld_d;
      lock_q      <= lock_d;
      gnt_q       <= gnt_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.ack   = ack_q;
  assign bus.rdata = rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with two-cycle accesses,
// one with single-cycle accesses for back-to-back streaming.
module tb_mem_port_arbiter;

  logic        clock;
  logic        reset;

  logic        mem_en_a, mem_we_a;
  logic [16:0] mem_addr_a;
  logic [31:0] mem_wdata_a, mem_rdata_a;
  logic        mem_en_b, mem_we_b;
  logic [16:0] mem_addr_b;
  logic [31:0] mem_wdata_b, mem_rdata_b;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter_if #(.NREQ(2)) bus_a ();
  mem_port_arbiter_if #(.NREQ(2)) bus_b ();

  mem_port_arbiter #(.NREQ(2), .ACCESS_CYCLES(2)) dut_a (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus_a),
    .mem_en    (mem_en_a),
    .mem_we    (mem_we_a),
    .mem_addr  (mem_addr_a),
    .mem_wdata (mem_wdata_a),
    .mem_rdata (mem_rdata_a)
  );

  mem_port_arbiter #(.NREQ(2), .ACCESS_CYCLES(1)) dut_b (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus_b),
    .mem_en    (mem_en_b),
    .mem_we    (mem_we_b),
    .mem_addr  (mem_addr_b),
    .mem_wdata (mem_wdata_b),
    .mem_rdata (mem_rdata_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_ack(input int budget, output int cycles, output logic [1:0] seen);
    cycles = 0;
    seen   = '0;
    while (seen == '0 && cycles < budget) begin
      tick();
      cycles++;
      seen = bus_a.ack;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  int          cyc;
  logic [1:0]  seen;
  logic [16:0] addrs [4];
  logic [1:0]  rr_exp [4];

  initial begin
    addrs  = '{17'h00011, 17'h00022, 17'h10033, 17'h1FF44};
    rr_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
    reset = 1'b1;
    bus_a.req = '0; bus_a.we = '0; bus_a.lock = '0; bus_a.addr = '0; bus_a.wdata = '0;
    bus_b.req = '0; bus_b.we = '0; bus_b.lock = '0; bus_b.addr = '0; bus_b.wdata = '0;
    mem_rdata_a = '0;
    mem_rdata_b = '0;
    do_reset();

    // Reset state
    check("rst_gnt",    bus_a.gnt,   2'b00);
    check("rst_ack",    bus_a.ack,   2'b00);
    check("rst_rdata",  bus_a.rdata, 32'h0);
    check("rst_mem_en", mem_en_a,    1'b0);

    // 1: port0 read
    bus_a.req[0]       = 1'b1;
    bus_a.addr[16:0]   = 17'h00100;
    mem_rdata_a        = 32'h12345678;
    tick();
    check("t1_mem_en",   mem_en_a,   1'b1);
    check("t1_mem_we",   mem_we_a,   1'b0);
    check("t1_mem_addr", mem_addr_a, 17'h00100);
    check("t1_gnt",      bus_a.gnt,  2'b01);
    wait_ack(10, cyc, seen);
    bus_a.req = '0;
    check("t1_ack",      seen,        2'b01);
    check("t1_latency",  cyc + 1,     3);
    check("t1_rdata",    bus_a.rdata, 32'h12345678);
    check("t1_en_off",   mem_en_a,    1'b0);
    check("t1_gnt_off",  bus_a.gnt,   2'b00);
    tick();
    check("t1_ack_pulse", bus_a.ack,  2'b00);

    // 2: simultaneous requests, alternate grants
    do_reset();
    bus_a.addr = {17'h00200, 17'h00100};
    bus_a.req  = 2'b11;
    for (int n = 0; n < 4; n++) begin
      wait_ack(10, cyc, seen);
      if (n == 3) bus_a.req = '0;
      check($sformatf("t2_ack%0d", n), seen, rr_exp[n]);
      check($sformatf("t2_lat%0d", n), cyc,  3);
    end

    // 3: port1 write, rdata must not change
    mem_rdata_a       = 32'hA5A5A5A5;
    bus_a.req[1]      = 1'b1;
    bus_a.we[1]       = 1'b1;
    bus_a.addr[33:17] = 17'h1FFFF;
    bus_a.wdata[63:32] = 32'hDEADBEEF;
    for (int n = 0; n < 2; n++) begin
      tick();
      check($sformatf("t3_we%0d", n),    mem_we_a,    1'b1);
      check($sformatf("t3_addr%0d", n),  mem_addr_a,  17'h1FFFF);
      check($sformatf("t3_wdata%0d", n), mem_wdata_a, 32'hDEADBEEF);
      check($sformatf("t3_gnt%0d", n),   bus_a.gnt,   2'b10);
    end
    tick();
    bus_a.req = '0;
    bus_a.we  = '0;
    check("t3_ack",   bus_a.ack,   2'b10);
    check("t3_rdata", bus_a.rdata, 32'h12345678);
    check("t3_we_off", mem_we_a,   1'b0);

    // 4: locked read-modify-write on port0 while port1 waits
    do_reset();
    mem_rdata_a = 32'h0000CAFE;
    bus_a.addr  = {17'h00020, 17'h00010};
    bus_a.we    = 2'b00;
    bus_a.lock  = 2'b01;
    bus_a.req   = 2'b11;
    for (int n = 0; n < 3; n++) begin
      tick();
      check($sformatf("t4_rd_gnt%0d", n), bus_a.gnt, 2'b01);
    end
    check("t4_rd_ack",   bus_a.ack,   2'b01);
    check("t4_rd_rdata", bus_a.rdata, 32'h0000CAFE);
    bus_a.we[0]        = 1'b1;
    bus_a.lock[0]      = 1'b0;
    bus_a.wdata[31:0]  = 32'h0BADF00D;
    tick();
    check("t4_wr_gnt0",  bus_a.gnt,   2'b01);
    check("t4_wr_we",    mem_we_a,    1'b1);
    check("t4_wr_addr",  mem_addr_a,  17'h00010);
    check("t4_wr_wdata", mem_wdata_a, 32'h0BADF00D);
    tick();
    check("t4_wr_gnt1",  bus_a.gnt,   2'b01);
    tick();
    check("t4_wr_ack",   bus_a.ack,   2'b01);
    check("t4_wr_gnt2",  bus_a.gnt,   2'b00);
    bus_a.req[0] = 1'b0;
    bus_a.we     = '0;
    tick();
    check("t4_p1_gnt",   bus_a.gnt,   2'b10);
    check("t4_p1_addr",  mem_addr_a,  17'h00020);
    tick();
    tick();
    check("t4_p1_ack",   bus_a.ack,   2'b10);
    bus_a.req = '0;

    // 5: reset during the second access cycle
    do_reset();
    mem_rdata_a      = 32'h5555AAAA;
    bus_a.addr[16:0] = 17'h00ABC;
    bus_a.req[0]     = 1'b1;
    tick();
    tick();
    check("t5_pre_en", mem_en_a, 1'b1);
    reset = 1'b1;
    #1;
    check("t5_rst_en",    mem_en_a,    1'b0);
    check("t5_rst_gnt",   bus_a.gnt,   2'b00);
    check("t5_rst_addr",  mem_addr_a,  17'h0);
    check("t5_rst_rdata", bus_a.rdata, 32'h0);
    tick();
    check("t5_no_ack",    bus_a.ack,   2'b00);
    reset = 1'b0;
    wait_ack(10, cyc, seen);
    bus_a.req = '0;
    check("t5_ack",     seen,        2'b01);
    check("t5_latency", cyc,         3);
    check("t5_rdata",   bus_a.rdata, 32'h5555AAAA);

    // 6: single-cycle accesses streamed back to back
    bus_b.req[0] = 1'b1;
    for (int n = 0; n < 4; n++) begin
      bus_b.addr[16:0] = addrs[n];
      mem_rdata_b      = {16'hC0DE, 16'(n)};
      tick();
      check($sformatf("t6_en%0d", n),   mem_en_b,   1'b1);
      check($sformatf("t6_addr%0d", n), mem_addr_b, addrs[n]);
      check($sformatf("t6_noack%0d", n), bus_b.ack, 2'b00);
      bus_b.addr[16:0] = 17'h0BEEF;
      tick();
      if (n == 3) bus_b.req = '0;
      check($sformatf("t6_ack%0d", n),   bus_b.ack,   2'b01);
      check($sformatf("t6_rdata%0d", n), bus_b.rdata, {16'hC0DE, 16'(n)});
    end
    tick();
    check("t6_idle_en",  mem_en_b,  1'b0);
    check("t6_idle_ack", bus_b.ack, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
